axistream_snoop_fwd_nslot: RTL and testbench
============================================

# axistream_snoop_fwd_nslot

Parametrised successor to the single-buffer snooper/forwarder of the packet filter. Passively snoops an AXI Stream, captures whole packets into a ring of NUM_SLOTS packet slots, and holds each one until the filter core returns an accept/reject verdict. Accepted packets are replayed in arrival order on an AXI Stream master; rejected packets are discarded. Packets that find no free slot are dropped and counted.

## Interface
- DATA_WIDTH, 64: stream data width in bits; power of two, 8 to 512.
- SLOT_ADDR_WIDTH, 8: each slot holds 2**SLOT_ADDR_WIDTH beats.
- NUM_SLOTS, 4: number of slots; power of two, 2 to 16.
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- axi_aclk  in  1  sole clock.
- axi_aresetn  in  1  reset, asynchronous assert, active-low.
- snoop_TDATA  in  DATA_WIDTH  snooped data.
- snoop_TVALID, snoop_TREADY, snoop_TLAST  in  1 each  snooped handshake. All are inputs; the block never back-pressures the snooped stream.
- filt_valid  in  1  verdict strobe for the oldest PEND slot.
- filt_accept  in  1  verdict value: 1 = forward, 0 = discard.
- pend_valid  out  1  at least one slot is in PEND.
- fwd_TDATA  out  DATA_WIDTH  forwarded data, registered.
- fwd_TVALID, fwd_TLAST  out  1 each  forward handshake.
- fwd_TREADY  in  1  downstream ready.
- drop_count, reject_count, trunc_count  out  CNT_WIDTH each  statistics counters; each wraps at 2**CNT_WIDTH.
- slots_used  out  $clog2(NUM_SLOTS)+1  number of slots that are not FREE.

## Operation
- A snooped beat is taken when snoop_TVALID & snoop_TREADY.
- Slot state values: FREE, FILL, PEND, ACC, REJ. Three ring pointers: wr_ptr (filling), vd_ptr (next verdict), rd_ptr (forwarding).
- First beat of a packet:
  - If slot[wr_ptr] is FREE: slot goes to FILL, beat is stored at offset 0.
  - Otherwise: the whole packet, through its TLAST, is ignored and drop_count increments once.
- Beats beyond offset 2**SLOT_ADDR_WIDTH-1 are discarded. The stored length saturates and trunc_count increments once per packet.
- TLAST beat: the slot records its length (beats-1) and goes to PEND; wr_ptr advances. A single-beat packet goes FREE→PEND in one capture.
- Verdict: filt_valid while slot[vd_ptr] is PEND sets it to ACC or REJ and advances vd_ptr. A verdict with no PEND slot is ignored and changes no state.
- Forwarder:
  - slot[rd_ptr] REJ: freed in one cycle; reject_count increments.
  - slot[rd_ptr] ACC: beats 0..length are streamed; TLAST accompanies beat length; the slot goes FREE on the TLAST handshake and rd_ptr advances.
- Slot storage is one simple-dual-port RAM of NUM_SLOTS·2**SLOT_ADDR_WIDTH words, addressed {slot, offset}.

## Timing
- Reset: every slot FREE, all pointers 0, fwd_TVALID=0, fwd_TLAST=0, fwd_TDATA=0, pend_valid=0, all counters 0, slots_used=0. Reset mid-packet abandons the packet; capture resumes at the next first beat after release.
- RAM read latency is 1 cycle. A 2-entry output skid sustains 1 beat/cycle while fwd_TREADY=1.
- The first fwd_TVALID is asserted exactly 2 cycles after the accept verdict edge, provided the slot is at rd_ptr.
- AXIS rule: once fwd_TVALID=1, fwd_TDATA and fwd_TLAST hold until the handshake.
- Back-to-back accepted packets: the next packet's first beat is valid the cycle after the previous TLAST handshake.
- A slot freed in cycle N is reusable by a first beat in cycle N+1, not N.
- A verdict for a slot whose TLAST is captured in the same cycle is ignored, because the slot is not yet PEND.
- slots_used and pend_valid are registered and reflect state after the current edge.

## Structure
- Package axistream_snoop_fwd_pkg holds the slot_state_t enum and a localparam helper for the slots_used width.
- Sub-module snoop_fwd_slot_ram: simple-dual-port, 1-cycle read, no reset on contents.

## Test plan
- Defaults, one 5-beat packet, accept, fwd_TREADY=1 → 5 beats out in order with TLAST on beat 5; first fwd_TVALID 2 cycles after verdict; counters stay 0.
- Four packets, verdicts A,R,A,R → only packets 1 and 3 forwarded, reject_count=2, slots_used returns to 0.
- Five packets with no verdicts and NUM_SLOTS=4 → packet 5 not stored, drop_count=1, slots_used=4, pend_valid=1.
- 300-beat packet with SLOT_ADDR_WIDTH=8 → 256 beats forwarded, trunc_count=1, TLAST on beat 256.
- Accepted 3-beat packet with fwd_TREADY toggling 1,0,0,1… → no beat lost or duplicated; data stable while stalled.
- axi_aresetn pulsed low mid-forward → outputs 0 immediately; a fresh packet afterwards forwards correctly from slot 0.

Source files
------------

// File: rtl/axistream_snoop_fwd_pkg.sv
// Shared types for the multi-slot AXI Stream snooper/forwarder.
package axistream_snoop_fwd_pkg;

    // Lifecycle of one packet slot.
    typedef enum logic [2:0] {
        SLOT_FREE = 3'd0,
        SLOT_FILL = 3'd1,
        SLOT_PEND = 3'd2,
        SLOT_ACC  = 3'd3,
        SLOT_REJ  = 3'd4
    } slot_state_t;

    // Read-issue side of the forwarder: idle between packets, or walking the offsets of one slot.
    typedef enum logic {
        ISS_IDLE = 1'b0,
        ISS_READ = 1'b1
    } iss_state_t;

    // Width of a count that can reach num_slots inclusive.
    function automatic int used_width(input int num_slots);
        return $clog2(num_slots) + 1;
    endfunction

endpackage

// File: rtl/snoop_fwd_slot_ram.sv
// Simple-dual-port packet storage: one write port, one read port with 1-cycle registered read.
module snoop_fwd_slot_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write captured beats and register the read word.
    // NOTE: storage has no reset so it maps onto block RAM; slot state, not contents, says what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/axistream_snoop_fwd_nslot.sv
// Snoops an AXI Stream into a ring of packet slots, waits for a verdict per packet,
// replays accepted packets in arrival order and discards rejected ones.
module axistream_snoop_fwd_nslot
    import axistream_snoop_fwd_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int SLOT_ADDR_WIDTH = 8,
    parameter int NUM_SLOTS       = 4,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                               axi_aclk,
    input  logic                               axi_aresetn,
    input  logic [DATA_WIDTH-1:0]              snoop_TDATA,
    input  logic                               snoop_TVALID,
    input  logic                               snoop_TREADY,
    input  logic                               snoop_TLAST,
    input  logic                               filt_valid,
    input  logic                               filt_accept,
    output logic                               pend_valid,
    output logic [DATA_WIDTH-1:0]              fwd_TDATA,
    output logic                               fwd_TVALID,
    output logic                               fwd_TLAST,
    input  logic                               fwd_TREADY,
    output logic [CNT_WIDTH-1:0]               drop_count,
    output logic [CNT_WIDTH-1:0]               reject_count,
    output logic [CNT_WIDTH-1:0]               trunc_count,
    output logic [used_width(NUM_SLOTS)-1:0]   slots_used
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int RAM_AW = SLOT_W + SLOT_ADDR_WIDTH;
    localparam int USED_W = used_width(NUM_SLOTS);

    typedef logic [SLOT_W-1:0]          ptr_t;
    typedef logic [SLOT_ADDR_WIDTH-1:0] off_t;

    localparam ptr_t                 PTR_ONE  = 1;
    localparam off_t                 OFF_ONE  = 1;
    localparam off_t                 OFF_MAX  = '1;
    localparam logic [USED_W-1:0]    USED_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;

    // Slot bookkeeping
    slot_state_t slot_state     [NUM_SLOTS];
    slot_state_t slot_state_nxt [NUM_SLOTS];
    off_t        slot_len       [NUM_SLOTS];
    ptr_t        wr_ptr, vd_ptr, rd_ptr;
    logic [USED_W-1:0] used_nxt;
    logic        pend_nxt;

    // Capture side
    logic snoop_beat, first_beat, head_free, at_max;
    logic store_first, store_next, ram_we, trunc_hit, drop_hit, close_pkt;
    logic in_pkt, cap_drop, cap_trunc;
    off_t cap_off, cap_next, wr_off, close_len;
    logic verdict_hit;

    // Read-issue side
    iss_state_t iss_state, iss_state_nxt;
    off_t       iss_off, rd_off;
    logic       rd_en, rd_last, rej_free, iss_adv;
    logic       head_acc, head_rej, head_busy, credit_ok;
    logic [1:0] occ;

    // Read pipeline and output skid
    logic                  rd_pend, rd_pend_last;
    ptr_t                  rd_pend_slot;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    ptr_t                  out_slot;
    logic                  skid_valid, skid_last;
    logic [DATA_WIDTH-1:0] skid_data;
    ptr_t                  skid_slot;
    logic                  pop, acc_free;

    snoop_fwd_slot_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (RAM_AW)
    ) u_ram (
        .clk     (axi_aclk),
        .wr_en   (ram_we),
        .wr_addr ({wr_ptr, wr_off}),
        .wr_data (snoop_TDATA),
        .rd_en   (rd_en),
        .rd_addr ({rd_ptr, rd_off}),
        .rd_data (ram_rd_data)
    );

    // Decode each snooped beat into store / truncate / drop / close actions.
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        snoop_beat  = snoop_TVALID & snoop_TREADY;
        first_beat  = snoop_beat & ~in_pkt;
        head_free   = (slot_state[wr_ptr] == SLOT_FREE);
        at_max      = (cap_off == OFF_MAX);
        cap_next    = cap_off + OFF_ONE;
        store_first = first_beat & head_free;
        store_next  = snoop_beat & in_pkt & ~cap_drop & ~at_max;
        ram_we      = store_first | store_next;
        wr_off      = store_first ? '0 : cap_next;
        trunc_hit   = snoop_beat & in_pkt & ~cap_drop & at_max & ~cap_trunc;
        drop_hit    = first_beat & ~head_free;
        close_pkt   = snoop_beat & snoop_TLAST & (store_first | (in_pkt & ~cap_drop));
        close_len   = store_first ? '0 : (at_max ? cap_off : cap_next);
        verdict_hit = filt_valid & (slot_state[vd_ptr] == SLOT_PEND);
    end

    // Track packet boundaries, the write offset and the fill pointer.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            in_pkt    <= 1'b0;
            cap_drop  <= 1'b0;
            cap_trunc <= 1'b0;
            cap_off   <= '0;
            wr_ptr    <= '0;
        end else begin
            if (snoop_beat) begin
                in_pkt <= ~snoop_TLAST;
                if (first_beat) begin
                    cap_drop  <= ~head_free;
                    cap_trunc <= 1'b0;
                    cap_off   <= '0;
                end else if (!cap_drop) begin
                    if (at_max) cap_trunc <= 1'b1;
                    else        cap_off   <= cap_next;
                end
            end
            if (close_pkt) wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    // Record the last stored offset of each closed packet.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_len[i] <= '0;
        end else if (close_pkt) begin
            slot_len[wr_ptr] <= close_len;
        end
    end

    // Output credit: at most two beats held in the skid plus in flight from the RAM.
    always_comb begin
        pop       = fwd_TVALID & fwd_TREADY;
        acc_free  = pop & fwd_TLAST;
        occ       = {1'b0, fwd_TVALID} + {1'b0, skid_valid} + {1'b0, rd_pend};
        credit_ok = (occ < 2'd2) || ((occ == 2'd2) && pop);
        head_busy = (rd_pend && (rd_pend_slot == rd_ptr)) ||
                    (fwd_TVALID && (out_slot == rd_ptr)) ||
                    (skid_valid && (skid_slot == rd_ptr));
        head_acc  = (slot_state[rd_ptr] == SLOT_ACC) && !head_busy;
        head_rej  = (slot_state[rd_ptr] == SLOT_REJ);
    end

    // Issue FSM state register.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) iss_state <= ISS_IDLE;
        else              iss_state <= iss_state_nxt;
    end

    // Issue FSM next state: enter READ for multi-beat packets, leave after the last read.
    always_comb begin
        iss_state_nxt = iss_state;
        case (iss_state)
            ISS_IDLE: if (head_acc && credit_ok && (slot_len[rd_ptr] != '0)) iss_state_nxt = ISS_READ;
            ISS_READ: if (credit_ok && (iss_off == slot_len[rd_ptr]))        iss_state_nxt = ISS_IDLE;
            default:  iss_state_nxt = ISS_IDLE;
        endcase
    end

    // Issue FSM outputs: RAM read strobe, offset, reject free and pointer advance.
    always_comb begin
        rd_en    = 1'b0;
        rd_off   = iss_off;
        rd_last  = 1'b0;
        rej_free = 1'b0;
        iss_adv  = 1'b0;
        case (iss_state)
            ISS_IDLE: begin
                if (head_rej) begin
                    rej_free = 1'b1;
                    iss_adv  = 1'b1;
                end else if (head_acc && credit_ok) begin
                    rd_en   = 1'b1;
                    rd_off  = '0;
                    rd_last = (slot_len[rd_ptr] == '0);
                    iss_adv = rd_last;
                end
            end
            ISS_READ: begin
                if (credit_ok) begin
                    rd_en   = 1'b1;
                    rd_last = (iss_off == slot_len[rd_ptr]);
                    iss_adv = rd_last;
                end
            end
            default: ;
        endcase
    end

    // Advance the read offset and the forwarding pointer as reads are issued.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            iss_off <= '0;
            rd_ptr  <= '0;
        end else begin
            if (rd_en)   iss_off <= rd_off + OFF_ONE;
            if (iss_adv) rd_ptr  <= rd_ptr + PTR_ONE;
        end
    end

    // Move RAM words into the registered output, spilling into the skid entry while stalled.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            rd_pend_slot <= '0;
            fwd_TVALID   <= 1'b0;
            fwd_TLAST    <= 1'b0;
            fwd_TDATA    <= '0;
            out_slot     <= '0;
            skid_valid   <= 1'b0;
            skid_last    <= 1'b0;
            skid_data    <= '0;
            skid_slot    <= '0;
        end else begin
            rd_pend      <= rd_en;
            rd_pend_last <= rd_last;
            rd_pend_slot <= rd_ptr;
            if (!fwd_TVALID || pop) begin
                if (skid_valid) begin
                    fwd_TVALID <= 1'b1;
                    fwd_TDATA  <= skid_data;
                    fwd_TLAST  <= skid_last;
                    out_slot   <= skid_slot;
                    skid_valid <= rd_pend;
                    skid_data  <= ram_rd_data;
                    skid_last  <= rd_pend_last;
                    skid_slot  <= rd_pend_slot;
                end else if (rd_pend) begin
                    fwd_TVALID <= 1'b1;
                    fwd_TDATA  <= ram_rd_data;
                    fwd_TLAST  <= rd_pend_last;
                    out_slot   <= rd_pend_slot;
                end else begin
                    fwd_TVALID <= 1'b0;
                    fwd_TLAST  <= 1'b0;
                end
            end else if (rd_pend) begin
                skid_valid <= 1'b1;
                skid_data  <= ram_rd_data;
                skid_last  <= rd_pend_last;
                skid_slot  <= rd_pend_slot;
            end
        end
    end

    // Next slot states; the four updaters touch disjoint states and therefore disjoint slots.
    always_comb begin
        slot_state_nxt = slot_state;
        if (store_first)    slot_state_nxt[wr_ptr]   = snoop_TLAST ? SLOT_PEND : SLOT_FILL;
        else if (close_pkt) slot_state_nxt[wr_ptr]   = SLOT_PEND;
        if (verdict_hit)    slot_state_nxt[vd_ptr]   = filt_accept ? SLOT_ACC : SLOT_REJ;
        if (rej_free)       slot_state_nxt[rd_ptr]   = SLOT_FREE;
        if (acc_free)       slot_state_nxt[out_slot] = SLOT_FREE;
        used_nxt = '0;
        pend_nxt = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_state_nxt[i] != SLOT_FREE) used_nxt = used_nxt + USED_ONE;
            if (slot_state_nxt[i] == SLOT_PEND) pend_nxt = 1'b1;
        end
    end

    // Register slot states, verdict pointer and the derived occupancy flags.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_state[i] <= SLOT_FREE;
            vd_ptr     <= '0;
            pend_valid <= 1'b0;
            slots_used <= '0;
        end else begin
            slot_state <= slot_state_nxt;
            if (verdict_hit) vd_ptr <= vd_ptr + PTR_ONE;
            pend_valid <= pend_nxt;
            slots_used <= used_nxt;
        end
    end

    // Statistics counters, free-running and wrapping.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            drop_count   <= '0;
            reject_count <= '0;
            trunc_count  <= '0;
        end else begin
            if (drop_hit)  drop_count   <= drop_count + CNT_ONE;
            if (rej_free)  reject_count <= reject_count + CNT_ONE;
            if (trunc_hit) trunc_count  <= trunc_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_axistream_snoop_fwd_nslot.sv
// Directed bench for the multi-slot snooper/forwarder at default parameters.
module tb_axistream_snoop_fwd_nslot;

    localparam int DW = 64;
    localparam int CW = 32;

    logic          axi_aclk = 1'b0;
    logic          axi_aresetn = 1'b0;
    logic [DW-1:0] snoop_TDATA = '0;
    logic          snoop_TVALID = 1'b0;
    logic          snoop_TREADY = 1'b0;
    logic          snoop_TLAST = 1'b0;
    logic          filt_valid = 1'b0;
    logic          filt_accept = 1'b0;
    logic          pend_valid;
    logic [DW-1:0] fwd_TDATA;
    logic          fwd_TVALID;
    logic          fwd_TLAST;
    logic          fwd_TREADY = 1'b1;
    logic [CW-1:0] drop_count;
    logic [CW-1:0] reject_count;
    logic [CW-1:0] trunc_count;
    logic [2:0]    slots_used;

    always #5 axi_aclk = ~axi_aclk;

    axistream_snoop_fwd_nslot dut (
        .axi_aclk     (axi_aclk),
        .axi_aresetn  (axi_aresetn),
        .snoop_TDATA  (snoop_TDATA),
        .snoop_TVALID (snoop_TVALID),
        .snoop_TREADY (snoop_TREADY),
        .snoop_TLAST  (snoop_TLAST),
        .filt_valid   (filt_valid),
        .filt_accept  (filt_accept),
        .pend_valid   (pend_valid),
        .fwd_TDATA    (fwd_TDATA),
        .fwd_TVALID   (fwd_TVALID),
        .fwd_TLAST    (fwd_TLAST),
        .fwd_TREADY   (fwd_TREADY),
        .drop_count   (drop_count),
        .reject_count (reject_count),
        .trunc_count  (trunc_count),
        .slots_used   (slots_used)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] rx_data [$];
    logic        rx_last [$];

    // Record forwarded beats mid-cycle; the handshake completes at the following rising edge.
    always @(negedge axi_aclk) begin
        if (axi_aresetn && fwd_TVALID && fwd_TREADY) begin
            rx_data.push_back(fwd_TDATA);
            rx_last.push_back(fwd_TLAST);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_word(input int id, input int idx);
        return {id[31:0], idx[31:0]};
    endfunction

    task automatic step();
        @(posedge axi_aclk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_pkt(input int id, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            snoop_TVALID = 1'b1;
            snoop_TREADY = 1'b1;
            snoop_TDATA  = beat_word(id, b);
            snoop_TLAST  = (b == nbeats - 1);
            step();
        end
        snoop_TVALID = 1'b0;
        snoop_TREADY = 1'b0;
        snoop_TLAST  = 1'b0;
    endtask

    task automatic verdict(input logic acc);
        filt_valid  = 1'b1;
        filt_accept = acc;
        step();
        filt_valid  = 1'b0;
        filt_accept = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int k = 0;
        while (rx_data.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, rx_data.size(), n);
    endtask

    task automatic check_pkt(input string tag, input int base, input int id, input int len);
        for (int i = 0; i < len; i++) begin
            if (base + i < rx_data.size()) begin
                check($sformatf("%s_data%0d", tag, i), rx_data[base + i], beat_word(id, i));
                check($sformatf("%s_last%0d", tag, i), rx_last[base + i], (i == len - 1));
            end else begin
                check($sformatf("%s_missing%0d", tag, i), rx_data.size(), base + i + 1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;

        // Reset state
        idle(3);
        check("rst_tvalid", fwd_TVALID, 0);
        check("rst_tlast", fwd_TLAST, 0);
        check("rst_tdata", fwd_TDATA, 0);
        check("rst_pend", pend_valid, 0);
        check("rst_used", slots_used, 0);
        check("rst_drop", drop_count, 0);
        check("rst_reject", reject_count, 0);
        check("rst_trunc", trunc_count, 0);
        axi_aresetn = 1'b1;
        idle(2);

        // One 5-beat packet, accepted, sink always ready
        send_pkt(1, 5);
        check("t1_pend", pend_valid, 1);
        check("t1_used", slots_used, 1);
        verdict(1'b1);
        check("t1_lat0", fwd_TVALID, 0);
        step();
        check("t1_lat1", fwd_TVALID, 0);
        step();
        check("t1_lat2", fwd_TVALID, 1);
        check("t1_first_data", fwd_TDATA, beat_word(1, 0));
        wait_beats("t1_count", 5, 30);
        idle(3);
        check("t1_count_final", rx_data.size(), 5);
        check_pkt("t1", 0, 1, 5);
        check("t1_drop", drop_count, 0);
        check("t1_reject", reject_count, 0);
        check("t1_trunc", trunc_count, 0);
        check("t1_used_after", slots_used, 0);

        // Four packets, verdicts accept/reject/accept/reject
        rx_data.delete();
        rx_last.delete();
        send_pkt(2, 2);
        send_pkt(3, 1);
        send_pkt(4, 3);
        send_pkt(5, 4);
        check("t2_used_full", slots_used, 4);
        check("t2_pend", pend_valid, 1);
        verdict(1'b1);
        verdict(1'b0);
        verdict(1'b1);
        verdict(1'b0);
        wait_beats("t2_count", 5, 40);
        idle(5);
        check("t2_count_final", rx_data.size(), 5);
        check_pkt("t2_p1", 0, 2, 2);
        check_pkt("t2_p3", 2, 4, 3);
        check("t2_reject", reject_count, 2);
        check("t2_used_after", slots_used, 0);
        check("t2_pend_after", pend_valid, 0);

        // Five packets with no verdicts: the fifth finds no free slot
        rx_data.delete();
        rx_last.delete();
        for (int p = 0; p < 5; p++) send_pkt(10 + p, 2);
        idle(1);
        check("t3_drop", drop_count, 1);
        check("t3_used", slots_used, 4);
        check("t3_pend", pend_valid, 1);
        for (int p = 0; p < 4; p++) verdict(1'b0);
        idle(6);
        check("t3_reject", reject_count, 6);
        check("t3_used_after", slots_used, 0);
        check("t3_nothing_fwd", rx_data.size(), 0);

        // 300-beat packet truncated to 256 stored beats
        send_pkt(20, 300);
        check("t4_trunc", trunc_count, 1);
        verdict(1'b1);
        wait_beats("t4_count", 256, 600);
        idle(5);
        check("t4_count_final", rx_data.size(), 256);
        bad = 0;
        for (int i = 0; i < rx_data.size(); i++) begin
            if (rx_data[i] !== beat_word(20, i) || rx_last[i] !== (i == 255)) bad++;
        end
        check("t4_bad_beats", bad, 0);
        if (rx_last.size() > 255) check("t4_last_on_256", rx_last[255], 1);
        check("t4_used_after", slots_used, 0);

        // Accepted 3-beat packet with a stalling sink: ready pattern 1,0,0 repeating
        rx_data.delete();
        rx_last.delete();
        send_pkt(30, 3);
        verdict(1'b1);
        for (int i = 0; i < 30; i++) begin
            logic r;
            logic pv;
            r  = (i % 3 == 0);
            pv = fwd_TVALID;
            fwd_TREADY = r;
            step();
            if (pv && !r) begin
                check($sformatf("t5_hold_valid%0d", i), fwd_TVALID, 1);
                check($sformatf("t5_hold_data%0d", i), fwd_TDATA, beat_word(30, rx_data.size()));
                check($sformatf("t5_hold_last%0d", i), fwd_TLAST, (rx_data.size() == 2));
            end
        end
        fwd_TREADY = 1'b1;
        wait_beats("t5_count", 3, 20);
        idle(3);
        check("t5_count_final", rx_data.size(), 3);
        check_pkt("t5", 0, 30, 3);

        // Reset pulsed while a packet is stalled at the output
        rx_data.delete();
        rx_last.delete();
        fwd_TREADY = 1'b0;
        send_pkt(40, 4);
        verdict(1'b1);
        idle(4);
        check("t6_pre_valid", fwd_TVALID, 1);
        check("t6_pre_data", fwd_TDATA, beat_word(40, 0));
        #1;
        axi_aresetn = 1'b0;
        #1;
        check("t6_rst_valid", fwd_TVALID, 0);
        check("t6_rst_data", fwd_TDATA, 0);
        check("t6_rst_last", fwd_TLAST, 0);
        check("t6_rst_used", slots_used, 0);
        check("t6_rst_trunc", trunc_count, 0);
        step();
        axi_aresetn = 1'b1;
        step();
        fwd_TREADY = 1'b1;
        rx_data.delete();
        rx_last.delete();
        send_pkt(41, 2);
        verdict(1'b1);
        wait_beats("t6_count", 2, 20);
        idle(3);
        check("t6_count_final", rx_data.size(), 2);
        check_pkt("t6", 0, 41, 2);
        check("t6_reject", reject_count, 0);
        check("t6_drop", drop_count, 0);
        check("t6_used_after", slots_used, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
